// File: rtl/virtual_wire_bank.sv
// Multi-channel JTAG source/probe command bank with toggle/ack handshake.
// Optional command parity check: define VIRTUAL_WIRE_BANK_PARITY_EN.
module virtual_wire_bank #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DATA_WIDTH+ADDR_WIDTH+2:0]   host_cmd,
  output logic [DATA_WIDTH+1:0]              host_status,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_out,
  output logic [NUM_CHANNELS-1:0]            ch_update,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_in
);

  localparam int CW = DATA_WIDTH + ADDR_WIDTH + 3;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    CAPTURE,
    EXEC,
    ACK
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]           cmd_q;
  logic                    last_q, last_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_q, out_d;
  logic [NUM_CHANNELS-1:0] upd_q, upd_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic                    cmd_ok;

  // Unreset so ARM sees the true toggle level right after reset release.
  always_ff @(posedge clk) begin
    cmd_q <= host_cmd;
  end

`ifdef VIRTUAL_WIRE_BANK_PARITY_EN
  logic par_ok_q, par_ok_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_ok_q <= 1'b0;
    else          par_ok_q <= par_ok_d;
  end

  always_comb begin
    par_ok_d = par_ok_q;
    if (state_q == CAPTURE) par_ok_d = ~^cmd_q[CW-1:1];
  end

  assign cmd_ok = par_ok_q;
`else
  logic unused_par;
  assign unused_par = cmd_q[2];
  assign cmd_ok     = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARM;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      out_q   <= {NUM_CHANNELS{INIT_VALUE}};
      upd_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      out_q   <= out_d;
      upd_q   <= upd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    out_d   = out_q;
    upd_d   = '0;
    ack_d   = ack_q;
    err_d   = err_q;
    rd_d    = rd_q;
    unique case (state_q)
      ARM: begin
        last_d  = cmd_q[0];
        state_d = IDLE;
      end
      IDLE: begin
        if (cmd_q[0] != last_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        we_d    = cmd_q[1];
        addr_d  = cmd_q[3 +: ADDR_WIDTH];
        data_d  = cmd_q[3+ADDR_WIDTH +: DATA_WIDTH];
        last_d  = cmd_q[0];
        state_d = EXEC;
      end
      EXEC: begin
        err_d   = 1'b1;
        rd_d    = '0;
        state_d = ACK;
        // Unmatched addresses fall through as errors.
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (cmd_ok && addr_q == ADDR_WIDTH'(i)) begin
            err_d = 1'b0;
            if (we_q) begin
              out_d[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
              upd_d[i] = 1'b1;
              rd_d     = data_q;
            end else begin
              rd_d = ch_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      ACK: begin
        ack_d   = last_q;
        state_d = IDLE;
      end
      default: state_d = ARM;
    endcase
  end

  assign ch_out      = out_q;
  assign ch_update   = upd_q;
  assign host_status = {rd_q, err_q, ack_q};

endmodule

// File: tb/tb_virtual_wire_bank.sv
// Self-checking bench for virtual_wire_bank (3 channels, 32-bit data).
// Directed handshake cases followed by random commands against a model.
module tb_virtual_wire_bank;

  localparam int NC = 3;
  localparam int DW = 32;
  localparam int AW = 2;
`ifdef VIRTUAL_WIRE_BANK_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [DW+AW+2:0] host_cmd;
  logic [DW+1:0]    host_status;
  logic [NC*DW-1:0] ch_out;
  logic [NC-1:0]    ch_update;
  logic [NC*DW-1:0] ch_in;

  virtual_wire_bank #(
    .NUM_CHANNELS(NC),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .INIT_VALUE(32'h0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .host_cmd(host_cmd),
    .host_status(host_status),
    .ch_out(ch_out),
    .ch_update(ch_update),
    .ch_in(ch_in)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  logic        tog;
  logic        ack_m;
  logic [31:0] out_m [NC];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [95:0] model_out();
    return {out_m[2], out_m[1], out_m[0]};
  endfunction

  task automatic send(input logic we, input logic [1:0] addr,
                      input logic [31:0] data, input bit bad_par,
                      input bit glitch);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [2:0]  exp_upd;
    logic        p;
    logic [2:0]  seen;
    bit          valid;
    valid   = (int'(addr) < NC) && !(PEN && bad_par);
    exp_upd = '0;
    exp_rd  = '0;
    exp_err = !valid;
    if (valid && we) begin
      exp_upd = 3'b001 << addr;
      exp_rd  = data;
    end else if (valid) begin
      exp_rd = ch_in[32*addr +: 32];
    end
    @(posedge clk); #1;
    tog = ~tog;
    p   = ^{data, addr, we};
    if (bad_par) p = ~p;
    host_cmd = {data, addr, p, we, tog};
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 2) host_cmd[0] = ~tog;
      if (glitch && i == 3) host_cmd[0] = tog;
      chk($sformatf("upd_e%0d", i), 96'(ch_update),
          96'((i == 4) ? exp_upd : 3'b000));
      if (i == 4) begin
        if (valid && we) out_m[addr] = data;
        chk("ch_out", ch_out, model_out());
        chk("rd_data", 96'(host_status[33:2]), 96'(exp_rd));
        chk("err", 96'(host_status[1]), 96'(exp_err));
        chk("ack_hold", 96'(host_status[0]), 96'(ack_m));
      end
      if (i == 5) begin
        chk("ack", 96'(host_status[0]), 96'(tog));
        ack_m = tog;
      end
    end
    seen = '0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= ch_update;
    end
    chk("no_extra_upd", 96'(seen), 96'(0));
    chk("ch_out_stable", ch_out, model_out());
  endtask

  initial begin
    logic [2:0] seen;
    logic       ack_seen;
    reset_n  = 1'b0;
    tog      = 1'b1;
    ack_m    = 1'b0;
    host_cmd = 37'h1;
    ch_in    = {32'h0, 32'h12345678, 32'h0};
    for (int i = 0; i < NC; i++) out_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", 96'(host_status), 96'(0));
    chk("rst_out", ch_out, 96'(0));
    chk("rst_upd", 96'(ch_update), 96'(0));
    reset_n  = 1'b1;
    seen     = '0;
    ack_seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen     |= ch_update;
      ack_seen |= host_status[0];
    end
    chk("hi_tog_upd", 96'(seen), 96'(0));
    chk("hi_tog_ack", 96'(ack_seen), 96'(0));
    chk("hi_tog_out", ch_out, 96'(0));

    reset_n  = 1'b0;
    host_cmd = '0;
    tog      = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    send(1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("wr2_slice", 96'(ch_out[95:64]), 96'(32'hDEADBEEF));
    send(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
    send(1'b1, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0);
    send(1'b1, 2'd0, 32'hA5A5_5A5A, 1'b0, 1'b1);
`ifdef VIRTUAL_WIRE_BANK_PARITY_EN
    send(1'b1, 2'd0, 32'h1, 1'b1, 1'b0);
    send(1'b1, 2'd0, 32'h1, 1'b0, 1'b0);
    chk("par_slice", 96'(ch_out[31:0]), 96'(32'h1));
`endif

    @(posedge clk); #1;
    tog = ~tog;
    host_cmd = {32'h0BAD_F00D, 2'd1, ^{32'h0BAD_F00D, 2'd1, 1'b1}, 1'b1, tog};
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NC; i++) out_m[i] = '0;
    ack_m = 1'b0;
    chk("midrst_out", ch_out, model_out());
    chk("midrst_status", 96'(host_status), 96'(0));
    chk("midrst_upd", 96'(ch_update), 96'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen = '0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= ch_update;
    end
    chk("midrst_quiet_upd", 96'(seen), 96'(0));
    chk("midrst_quiet_status", 96'(host_status), 96'(0));

    for (int n = 0; n < 40; n++) begin
      ch_in = {$urandom, $urandom, $urandom};
      send(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom,
           1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
